ins_fetch: RTL

- Instruction fetch stage directly upstream of the instruction parser.
- Owns the program counter and issues sequential word fetches to instruction memory.
- Buffers returned words with their addresses in a small FIFO, then presents instruction and p_count to the parser over a valid/ready handshake.
- Accepts branch redirects from downstream; redirects flush buffered and in-flight fetches.

---
 rtl/upower_pkg.sv | 7 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/ins_fetch.sv | 101 ++++++++++
 3 files changed

// File: rtl/upower_pkg.sv
// upower_pkg: shared widths, PC step and fetch FSM encodings for the fetch stage.
package upower_pkg;
    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam int PC_STEP = 4;
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, DRAIN = 2'd2} fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO of {pc, word} entries; flush beats push and pop.
module fetch_fifo #(
    parameter int            DEPTH   = 2,
    parameter int            W       = 64,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             dout_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_d  = flush_i ? '0 : push_i ? nxt(wr_q) : wr_q;
        rd_d  = flush_i ? '0 : pop_i ? nxt(rd_q) : rd_q;
        cnt_d = flush_i ? '0 : cnt_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is reset so the head reads as RST_VAL straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_VAL;
        end else if (push_i && !flush_i) begin
            mem_q[wr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
endmodule

// File: rtl/ins_fetch.sv
// ins_fetch: owns the PC, issues credit-limited word fetches and hands buffered
// {pc, word} pairs to the parser; redirects flush buffered and in-flight fetches.
module ins_fetch
    import upower_pkg::*;
#(
    parameter int                ADDR_W   = upower_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  p_count,
    output logic               ins_valid,
    input  logic               ins_ready
);
    localparam int                OW   = $clog2(DEPTH) + 1;
    localparam int                FW   = ADDR_W + INSTR_W;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, target;
    logic [OW-1:0]     out_q, out_d, occ;
    logic [FW-1:0]     head;
    logic              issue, push, pop, empty, full, credit;
    logic              unused_ok;

    assign target    = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign credit    = ({1'b0, out_q} + {1'b0, occ}) < (OW + 1)'(DEPTH);
    assign issue     = imem_req & imem_gnt;
    assign push      = imem_rvalid & (state_q == RUN) & ~redirect;
    assign pop       = ins_valid & ins_ready;
    assign imem_addr = fetch_pc_q;
    assign {p_count, instruction} = head;
    assign unused_ok = ^{redirect_pc[1:0], full};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BOOT;
        else        state_q <= state_d;
    end

    // Requests are suppressed on a redirect cycle, so out_d there is the count after the response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = (redirect && out_d != '0) ? DRAIN : RUN;
            DRAIN:   state_d = (redirect || out_d != '0) ? DRAIN : RUN;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        imem_req  = (state_q == RUN) & credit & ~redirect;
        ins_valid = ~empty & ~redirect;
    end

    always_comb begin
        out_d      = out_q + OW'(issue) - OW'(imem_rvalid);
        fetch_pc_d = redirect ? target : issue ? fetch_pc_q + STEP : fetch_pc_q;
        resp_pc_d  = redirect ? target : push ? resp_pc_q + STEP : resp_pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .W       (FW),
        .RST_VAL ({RESET_PC, INSTR_W'(0)})
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect),
        .din_i   ({resp_pc_q, imem_rdata}),
        .dout_o  (head),
        .empty_o (empty),
        .full_o  (full),
        .count_o (occ)
    );

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n) !(imem_rvalid && full));
endmodule
